decoder_2to4_stream: RTL

Registered 2-to-4 one-hot decoder with valid/ready handshakes on both sides, a DEPTH-entry FIFO between them, and per-line saturating hit counters. It sits downstream of the 4-to-2 encoder path and turns a stream of 2-bit codes back into one-hot line selects. Codes are buffered so a stalled consumer never drops one. The counters give a readable histogram of decoded lines for debug and bring-up.

---
 rtl/decoder_2to4_stream.sv | 99 +++++++++
 1 files changed

// File: rtl/decoder_2to4_stream.sv
// Registered 2-to-4 one-hot decoder behind a DEPTH-entry FIFO with valid/ready
// handshakes on both sides and four saturating per-line hit counters.
module decoder_2to4_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             x,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [3:0]             y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] lvl,
    input  logic [1:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt,
    input  logic                   clr_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [3:0] onehot(input logic e, input logic [1:0] c);
        return e ? (4'b0001 << c) : 4'b0000;
    endfunction

    logic [2:0]       entry_p0 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] lvl_r;
    logic [CNT_W-1:0] cnt_r [4];

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       vld_p1;
    logic [2:0] head_p1;

    assign full     = (lvl_r == LVL_W'(DEPTH));
    assign empty    = (lvl_r == '0);
    assign in_ready = !full && rst_n;
    assign push     = in_valid && in_ready;
    assign pop      = vld_p1 && out_ready;

    // Input stage: capture {en, x} into the FIFO slot under the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_p0[wr_ptr] <= {en, x};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   lvl_r <= lvl_r + LVL_W'(1);
                2'b01:   lvl_r <= lvl_r - LVL_W'(1);
                default: lvl_r <= lvl_r;
            endcase
        end
    end

    // Output stage: head entry decoded straight from registered state.
    assign vld_p1    = !empty;
    assign head_p1   = entry_p0[rd_ptr];
    assign out_valid = vld_p1;
    assign y         = vld_p1 ? onehot(head_p1[2], head_p1[1:0]) : 4'b0000;
    assign lvl       = lvl_r;

    // A clear wins over an increment landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (pop && head_p1[2]) begin
            cnt_r[head_p1[1:0]] <= sat_inc(cnt_r[head_p1[1:0]]);
        end
    end

    assign cnt = cnt_r[cnt_sel];

endmodule
